stopwatch_ctrl: RTL and testbench

Control and sequencing block for the board stopwatch. It debounces the start/stop and lap pushbuttons and runs a start/stop/lap state machine. It gates the 1/100 s tick divider and owns the 4-digit BCD hundredths counter, a lap snapshot register and the 7-segment drive of HEX0..HEX3. It sits at board top level between the KEY inputs and the HEX/LEDR outputs, clocked from CLOCK_50.

---
 rtl/stopwatch_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop (and lap) keys, IDLE/RUN/STOP FSM, BCD hundredths
// counter and HEX0..HEX3 drive. Define STOPWATCH_LAP_EN to build the lap/freeze feature.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int DEB_CYC  = 1000000
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic        KEY1,
  input  logic        KEY2,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [1:0]  LEDR,
  output logic [15:0] CNT_BCD
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

`ifdef STOPWATCH_LAP_EN
  localparam int NKEY = 2;
  logic [NKEY-1:0] w_key_n;
  assign w_key_n = {KEY2, KEY1};
`else
  localparam int NKEY = 1;
  logic [NKEY-1:0] w_key_n;
  logic            w_unused_key2;
  assign w_key_n       = KEY1;
  assign w_unused_key2 = KEY2;
`endif

  // Reset asserts asynchronously and releases two CLOCK_50 edges after KEY0 rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Per key: 2-flop synchronizer, debounce counter, registered 1-cycle press event.
  logic [NKEY-1:0]  r_sync0;
  logic [NKEY-1:0]  r_sync1;
  logic [NKEY-1:0]  r_level;
  logic [NKEY-1:0]  r_evt;
  logic [DEB_W-1:0] r_deb_cnt [NKEY];

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync0 <= '1;
      r_sync1 <= '1;
      r_level <= '1;
      r_evt   <= '0;
      for (int k = 0; k < NKEY; k++) r_deb_cnt[k] <= '0;
    end else begin
      r_sync0 <= w_key_n;
      r_sync1 <= r_sync0;
      for (int k = 0; k < NKEY; k++) begin
        r_evt[k] <= 1'b0;
        if (r_sync1[k] == r_level[k]) begin
          r_deb_cnt[k] <= '0;
        end else if (r_deb_cnt[k] == DEB_LAST) begin
          r_deb_cnt[k] <= '0;
          r_level[k]   <= r_sync1[k];
          r_evt[k]     <= r_level[k];  // only a released->pressed acceptance is an event
        end else begin
          r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  logic w_ss;
  assign w_ss = r_evt[0];
`ifdef STOPWATCH_LAP_EN
  logic w_lap;
  assign w_lap = r_evt[1];
`endif

  // NOTE: blocking (=) is correct here: function locals are combinational temporaries.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          res[4*d +: 4] = 4'd0;
        end else begin
          res[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [15:0]      r_count;
`ifdef STOPWATCH_LAP_EN
  logic [15:0]      r_lap;
  logic             r_freeze;
`endif

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_count  <= '0;
`ifdef STOPWATCH_LAP_EN
      r_lap    <= '0;
      r_freeze <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div   <= '0;
          r_count <= '0;
          if (w_ss) r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_count <= bcd_inc(r_count);
          end else begin
            r_div <= r_div + 1'b1;
          end
          // ss has priority; a lap arriving in the same cycle is dropped.
          if (w_ss) begin
            r_state <= S_STOP;
`ifdef STOPWATCH_LAP_EN
          end else if (w_lap) begin
            if (r_freeze) begin
              r_freeze <= 1'b0;
            end else begin
              r_lap    <= r_count;
              r_freeze <= 1'b1;
            end
`endif
          end
        end
        S_STOP: begin
          // Divider keeps its phase while stopped so resuming neither loses nor gains a tick.
          if (w_ss) begin
            r_state <= S_RUN;
`ifdef STOPWATCH_LAP_EN
          end else if (w_lap) begin
            if (r_freeze) begin
              r_freeze <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_div   <= '0;
              r_count <= '0;
            end
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [15:0] w_disp;
`ifdef STOPWATCH_LAP_EN
  assign w_disp = r_freeze ? r_lap : r_count;
  assign LEDR   = {r_freeze, (r_state == S_RUN)};
`else
  assign w_disp = r_count;
  assign LEDR   = {1'b0, (r_state == S_RUN)};
`endif

  assign CNT_BCD = r_count;
  assign HEX0    = seg7(w_disp[3:0]);
  assign HEX1    = seg7(w_disp[7:4]);
  assign HEX2    = seg7(w_disp[11:8]);
  assign HEX3    = seg7(w_disp[15:12]);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYC=3; runs with or without
// STOPWATCH_LAP_EN, expectations adapt to the build.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB_CYC  = 3;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        KEY0     = 1'b1;
  logic        KEY1     = 1'b1;
  logic        KEY2     = 1'b1;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [1:0]  LEDR;
  logic [15:0] CNT_BCD;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .KEY1     (KEY1),
    .KEY2     (KEY2),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .LEDR     (LEDR),
    .CNT_BCD  (CNT_BCD)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic        k1;
    logic        k2;
    int          ncyc;
    logic [1:0]  ledr;
    logic [15:0] cnt;
    logic [15:0] disp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] ledr,
                            input logic [15:0] cnt, input logic [15:0] disp);
    check({tag, "_ledr"}, 32'(LEDR), 32'(ledr));
    check({tag, "_cnt"}, 32'(CNT_BCD), 32'(cnt));
    check({tag, "_hex"}, 32'({HEX3, HEX2, HEX1, HEX0}),
          32'({seg7(disp[15:12]), seg7(disp[11:8]), seg7(disp[7:4]), seg7(disp[3:0])}));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    // Key press drives at a negedge; its event fires 5 edges later, the state moves on the 6th.
    // Running count after edge 6+4m from the start press is m (BCD).
    vecs[0]  = '{1'b0, 1'b1, 2,   2'b00, 16'h0000, 16'h0000};  // 2-cycle glitch
    vecs[1]  = '{1'b1, 1'b1, 8,   2'b00, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 5,   2'b00, 16'h0000, 16'h0000};  // press, still IDLE
    vecs[3]  = '{1'b0, 1'b1, 1,   2'b01, 16'h0000, 16'h0000};  // first RUN cycle
    vecs[4]  = '{1'b0, 1'b1, 4,   2'b01, 16'h0001, 16'h0001};
    vecs[5]  = '{1'b1, 1'b1, 36,  2'b01, 16'h0010, 16'h0010};  // 40 cycles into RUN
    vecs[6]  = '{1'b0, 1'b0, 5,   2'b01, 16'h0011, 16'h0011};  // ss+lap collision
    vecs[7]  = '{1'b0, 1'b0, 1,   2'b00, 16'h0011, 16'h0011};  // STOP, freeze untouched
    vecs[8]  = '{1'b1, 1'b1, 100, 2'b00, 16'h0011, 16'h0011};  // holds in STOP
    vecs[9]  = '{1'b0, 1'b1, 6,   2'b01, 16'h0011, 16'h0011};  // resume, divider at 2
    vecs[10] = '{1'b0, 1'b1, 2,   2'b01, 16'h0012, 16'h0012};  // tick 2 cycles later
    vecs[11] = '{1'b1, 1'b1, 48,  2'b01, 16'h0024, 16'h0024};
    vecs[12] = '{1'b1, 1'b0, 6,   LAP ? 2'b11 : 2'b01, 16'h0025, 16'h0025};  // lap at 0025
    vecs[13] = '{1'b1, 1'b1, 16,  LAP ? 2'b11 : 2'b01, 16'h0029, LAP ? 16'h0025 : 16'h0029};
    vecs[14] = '{1'b1, 1'b0, 6,   2'b01, 16'h0031, 16'h0031};  // unfreeze
    vecs[15] = '{1'b1, 1'b1, 4,   2'b01, 16'h0032, 16'h0032};
    vecs[16] = '{1'b0, 1'b1, 6,   2'b00, 16'h0033, 16'h0033};  // stop
    vecs[17] = '{1'b1, 1'b1, 4,   2'b00, 16'h0033, 16'h0033};
    vecs[18] = '{1'b1, 1'b0, 6,   2'b00, LAP ? 16'h0000 : 16'h0033, LAP ? 16'h0000 : 16'h0033};
    vecs[19] = '{1'b1, 1'b1, 10,  2'b00, LAP ? 16'h0000 : 16'h0033, LAP ? 16'h0000 : 16'h0033};

    // Reset with no clock edge yet.
    #1 KEY0 = 1'b0;
    #2 check_outs("reset_noclk", 2'b00, 16'h0000, 16'h0000);
    step(2);
    KEY0 = 1'b1;
    step(4);
    check_outs("reset_released", 2'b00, 16'h0000, 16'h0000);

    for (int i = 0; i < NVEC; i++) begin
      KEY1 = vecs[i].k1;
      KEY2 = vecs[i].k2;
      step(vecs[i].ncyc);
      check_outs($sformatf("vec%0d", i), vecs[i].ledr, vecs[i].cnt, vecs[i].disp);
    end

    // Clean reset, then run to 0137 and assert KEY0 mid-cycle.
    KEY0 = 1'b0;
    step(2);
    KEY0 = 1'b1;
    step(4);
    check_outs("rst2", 2'b00, 16'h0000, 16'h0000);
    KEY1 = 1'b0;
    step(6);
    check_outs("mid_start", 2'b01, 16'h0000, 16'h0000);
    KEY1 = 1'b1;
    step(548);
    check_outs("mid_0137", 2'b01, 16'h0137, 16'h0137);
    #2 KEY0 = 1'b0;
    #1 check_outs("mid_async_rst", 2'b00, 16'h0000, 16'h0000);
    step(2);
    KEY0 = 1'b1;
    step(2);
    check_outs("mid_after_rel", 2'b00, 16'h0000, 16'h0000);
    step(40);
    check_outs("mid_idle_hold", 2'b00, 16'h0000, 16'h0000);

    // Wrap: 10000 ticks from IDLE.
    KEY1 = 1'b0;
    step(6);
    check_outs("wrap_start", 2'b01, 16'h0000, 16'h0000);
    KEY1 = 1'b1;
    step(344);
    check_outs("wrap_0086", 2'b01, 16'h0086, 16'h0086);
    step(39652);
    check_outs("wrap_9999", 2'b01, 16'h9999, 16'h9999);
    step(3);
    check_outs("wrap_9999_hold", 2'b01, 16'h9999, 16'h9999);
    step(1);
    check_outs("wrap_0000", 2'b01, 16'h0000, 16'h0000);
    step(4);
    check_outs("wrap_0001", 2'b01, 16'h0001, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
